product_accumulator_seq: RTL and testbench



---
 rtl/product_accumulator_seq_pkg.sv | 15 +
 rtl/product_accumulator_seq_if.sv | 29 ++
 rtl/product_accumulator_seq_acc_add_sat.sv | 25 ++
 rtl/product_accumulator_seq.sv | 145 ++++++++++++++
 tb/tb_product_accumulator_seq.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/product_accumulator_seq_pkg.sv
// Shared types and default widths for the product accumulator.
// The ACC_SATURATE_EN macro is consumed by acc_add_sat; nothing here depends on it.
package product_accumulator_pkg;

  localparam int DATA_W = 64;
  localparam int ACC_W  = 72;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/product_accumulator_seq_if.sv
// Product input and result output handshakes of the accumulator.
// The slave modport is the accumulator's view; master is the driver/consumer side.
interface product_accumulator_seq_if #(
  parameter int DATA_W = product_accumulator_pkg::DATA_W,
  parameter int ACC_W  = product_accumulator_pkg::ACC_W,
  parameter int LEN_W  = product_accumulator_pkg::LEN_W
) ();
  import product_accumulator_pkg::*;

  logic              iValid;
  logic              oReady;
  logic [DATA_W-1:0] iData;
  logic [LEN_W-1:0]  iLen;
  logic              oValid;
  logic              iReady;
  logic [ACC_W-1:0]  oData;
  logic              oOvf;

  modport slave (
    input  iValid, iData, iLen, iReady,
    output oReady, oValid, oData, oOvf
  );

  modport master (
    output iValid, iData, iLen, iReady,
    input  oReady, oValid, oData, oOvf
  );

endinterface

// File: rtl/product_accumulator_seq_acc_add_sat.sv
// ACC_W accumulator adder with carry-out; ACC_SATURATE_EN selects clamp-to-all-ones,
// otherwise the sum wraps modulo 2^ACC_W.
module acc_add_sat #(
  parameter int ACC_W  = product_accumulator_pkg::ACC_W,
  parameter int DATA_W = product_accumulator_pkg::DATA_W
) (
  input  logic [ACC_W-1:0]  i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);
  import product_accumulator_pkg::*;

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_a} + (ACC_W + 1)'(i_b);
  assign o_carry = w_full[ACC_W];

`ifdef ACC_SATURATE_EN
  assign o_sum = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator_seq.sv
// Dot-product accumulator behind the 32x32 multiplier: sums runs of iLen products
// and holds the result on a valid/ready output. Build option: ACC_SATURATE_EN.
module product_accumulator_seq #(
  parameter int DATA_W = product_accumulator_pkg::DATA_W,
  parameter int ACC_W  = product_accumulator_pkg::ACC_W,
  parameter int LEN_W  = product_accumulator_pkg::LEN_W
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iEn,
  input  logic                       iClr,
  product_accumulator_seq_if.slave   bus
);
  import product_accumulator_pkg::*;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   w_cnt_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               r_valid;
  logic               w_valid_nxt;

  logic               w_ready;
  logic               w_accept;
  logic [LEN_W-1:0]   w_len_first;
  logic [LEN_W-1:0]   w_cnt_inc;
  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;

  acc_add_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_add (
    .i_a     (r_acc),
    .i_b     (bus.iData),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // A beat coinciding with iClr is dropped even though oReady may be high.
  assign w_ready     = iEn && (r_state != HOLD);
  assign w_accept    = w_ready && bus.iValid && !iClr;
  assign w_len_first = (bus.iLen == '0) ? LEN_ONE : bus.iLen;
  assign w_cnt_inc   = r_cnt + LEN_ONE;

  // Next-state, accumulator, counter and result-flag logic.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_ovf_nxt   = r_ovf;
    w_valid_nxt = r_valid;

    if (iClr) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
    end else if (iEn) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_acc_nxt = ACC_W'(bus.iData);
            w_cnt_nxt = LEN_ONE;
            w_len_nxt = w_len_first;
            w_ovf_nxt = 1'b0;
            if (w_len_first == LEN_ONE) begin
              w_state_nxt = HOLD;
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = ACCUM;
              w_valid_nxt = 1'b0;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = w_cnt_inc;
            w_ovf_nxt = r_ovf | w_carry;
            if (w_cnt_inc == r_len) begin
              w_state_nxt = HOLD;
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = ACCUM;
            end
          end else begin
            w_state_nxt = ACCUM;
          end
        end
        HOLD: begin
          if (bus.iReady) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
          end else begin
            w_state_nxt = HOLD;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len   <= LEN_ONE;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_ovf   <= w_ovf_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign bus.oReady = w_ready;
  assign bus.oValid = r_valid;
  assign bus.oData  = r_acc;
  assign bus.oOvf   = r_ovf;

endmodule

// File: tb/tb_product_accumulator_seq.sv
// Self-checking bench: a 72-bit and a 64-bit accumulator share stimulus and are
// compared every cycle against a run-level model built on the exact (unbounded) sum.
module tb_product_accumulator_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en;
  logic clr;

  product_accumulator_seq_if #(.DATA_W(64), .ACC_W(72), .LEN_W(16)) b72 ();
  product_accumulator_seq_if #(.DATA_W(64), .ACC_W(64), .LEN_W(16)) b64 ();

  product_accumulator_seq #(.DATA_W(64), .ACC_W(72), .LEN_W(16)) dut72 (
    .iClk (clk), .iRst (rst), .iEn (en), .iClr (clr), .bus (b72.slave)
  );

  product_accumulator_seq #(.DATA_W(64), .ACC_W(64), .LEN_W(16)) dut64 (
    .iClk (clk), .iRst (rst), .iEn (en), .iClr (clr), .bus (b64.slave)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Result of a run whose exact sum is s, seen through a w-bit accumulator.
  function automatic logic [79:0] exp_data(input logic [79:0] s, input int w);
    logic [79:0] lim;
    lim = 80'd1 << w;
    if (s >= lim) begin
`ifdef ACC_SATURATE_EN
      return lim - 80'd1;
`else
      return s % lim;
`endif
    end
    return s;
  endfunction

  function automatic logic exp_ovf(input logic [79:0] s, input int w);
    logic [79:0] lim;
    lim = 80'd1 << w;
    return (s >= lim);
  endfunction

  // Run-level model: beats taken so far (0 = no run open), run length, exact sum.
  logic        m_hold;
  int          m_taken;
  int          m_len;
  logic [79:0] m_sum;

  always @(posedge clk) begin
    if (rst || clr) begin
      m_hold  <= 1'b0;
      m_taken <= 0;
      m_sum   <= 80'd0;
    end else if (en) begin
      if (m_hold) begin
        if (b72.iReady) m_hold <= 1'b0;
      end else if (b72.iValid) begin
        if (m_taken == 0) begin
          m_len <= (b72.iLen == 16'd0) ? 1 : int'(b72.iLen);
          m_sum <= {16'd0, b72.iData};
          if (b72.iLen <= 16'd1) begin
            m_hold  <= 1'b1;
            m_taken <= 0;
          end else begin
            m_taken <= 1;
          end
        end else begin
          m_sum <= m_sum + {16'd0, b72.iData};
          if (m_taken + 1 == m_len) begin
            m_hold  <= 1'b1;
            m_taken <= 0;
          end else begin
            m_taken <= m_taken + 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready72", {79'd0, b72.oReady}, {79'd0, en && !m_hold});
      chk("ready64", {79'd0, b64.oReady}, {79'd0, en && !m_hold});
      chk("valid72", {79'd0, b72.oValid}, {79'd0, m_hold});
      chk("valid64", {79'd0, b64.oValid}, {79'd0, m_hold});
      if (m_hold) begin
        chk("data72", {8'd0, b72.oData}, exp_data(m_sum, 72));
        chk("data64", {16'd0, b64.oData}, exp_data(m_sum, 64));
        chk("ovf72", {79'd0, b72.oOvf}, {79'd0, exp_ovf(m_sum, 72)});
        chk("ovf64", {79'd0, b64.oOvf}, {79'd0, exp_ovf(m_sum, 64)});
      end
    end
  end

  task automatic set_in(input logic v, input logic [63:0] d, input logic [15:0] l);
    b72.iValid = v; b72.iData = d; b72.iLen = l;
    b64.iValid = v; b64.iData = d; b64.iLen = l;
  endtask

  task automatic set_rdy(input logic r);
    b72.iReady = r;
    b64.iReady = r;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Present one beat from posedge+2 until it is taken; returns at posedge+2 after acceptance.
  task automatic send(input logic [63:0] d, input logic [15:0] l);
    int n;
    n = 0;
    set_in(1'b1, d, l);
    @(negedge clk);
    while (!(b72.oReady && en) && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n >= 50) $display("FAIL send_timeout: got %0d cycles expected fewer than 50", n);
    else n_pass++;
    @(posedge clk);
    #2;
    set_in(1'b0, 64'd0, 16'd0);
  endtask

  logic [63:0] rd;
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0;
    set_in(1'b0, 64'd0, 16'd0);
    set_rdy(1'b1);

    // Reset
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_valid", {79'd0, b72.oValid}, 80'd0);
    chk("rst_data", {8'd0, b72.oData}, 80'd0);
    chk("rst_ovf", {79'd0, b64.oOvf}, 80'd0);
    chk("rst_ready", {79'd0, b72.oReady}, 80'd1);
    @(posedge clk); #2;
    rst = 1'b0;

    // Basic run of four
    send(64'd1, 16'd4); send(64'd2, 16'd4); send(64'd3, 16'd4); send(64'd4, 16'd4);
    @(negedge clk);
    chk("basic_valid", {79'd0, b72.oValid}, 80'd1);
    chk("basic_data", {8'd0, b72.oData}, 80'd10);
    chk("basic_ovf", {79'd0, b72.oOvf}, 80'd0);
    chk("basic_bubble", {79'd0, b72.oReady}, 80'd0);
    @(negedge clk);
    chk("basic_drop", {79'd0, b72.oValid}, 80'd0);
    chk("basic_rdy", {79'd0, b72.oReady}, 80'd1);
    @(posedge clk); #2;
    send(64'd5, 16'd1);
    idle(2);

    // Backpressure
    set_rdy(1'b0);
    send(64'd5, 16'd2); send(64'd7, 16'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", {79'd0, b72.oValid}, 80'd1);
      chk("bp_data", {8'd0, b72.oData}, 80'd12);
      chk("bp_ready", {79'd0, b72.oReady}, 80'd0);
    end
    set_rdy(1'b1);
    @(negedge clk);
    chk("bp_release_valid", {79'd0, b72.oValid}, 80'd0);
    chk("bp_release_ready", {79'd0, b72.oReady}, 80'd1);
    idle(1);

    // Overflow on the 64-bit instance
    send(ONES64, 16'd2); send(ONES64, 16'd2);
    @(negedge clk);
`ifdef ACC_SATURATE_EN
    chk("ovf64_data", {16'd0, b64.oData}, {16'd0, ONES64});
`else
    chk("ovf64_data", {16'd0, b64.oData}, 80'h0000_FFFF_FFFF_FFFF_FFFE);
`endif
    chk("ovf64_flag", {79'd0, b64.oOvf}, 80'd1);
    chk("ovf72_data", {8'd0, b72.oData}, 80'h0001_FFFF_FFFF_FFFF_FFFE);
    chk("ovf72_flag", {79'd0, b72.oOvf}, 80'd0);
    idle(2);

    // Abort with a beat present
    send(64'd10, 16'd4); send(64'd20, 16'd4);
    set_in(1'b1, 64'd100, 16'd4);
    clr = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    set_in(1'b0, 64'd0, 16'd0);
    @(negedge clk);
    chk("clr_valid", {79'd0, b72.oValid}, 80'd0);
    chk("clr_data", {8'd0, b72.oData}, 80'd0);
    chk("clr_ready", {79'd0, b72.oReady}, 80'd1);
    @(posedge clk); #2;
    send(64'd9, 16'd0);
    @(negedge clk);
    chk("len0_valid", {79'd0, b72.oValid}, 80'd1);
    chk("len0_data", {8'd0, b72.oData}, 80'd9);
    idle(2);

    // Freeze mid-run
    send(64'd1, 16'd3);
    en = 1'b0;
    set_in(1'b1, 64'd1, 16'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("frz_ready", {79'd0, b72.oReady}, 80'd0);
      chk("frz_valid", {79'd0, b72.oValid}, 80'd0);
    end
    @(posedge clk); #2;
    en = 1'b1;
    send(64'd1, 16'd3); send(64'd1, 16'd3);
    @(negedge clk);
    chk("frz_valid_end", {79'd0, b72.oValid}, 80'd1);
    chk("frz_data", {8'd0, b72.oData}, 80'd3);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 49) == 0);
      en  = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0:       rd = ONES64;
        1:       rd = 64'($urandom_range(0, 255));
        default: rd = {$urandom, $urandom};
      endcase
      set_in($urandom_range(0, 3) != 0, rd, 16'($urandom_range(0, 5)));
      set_rdy($urandom_range(0, 2) != 0);
      @(posedge clk); #2;
    end
    rst = 1'b0; clr = 1'b0; en = 1'b1;
    set_in(1'b0, 64'd0, 16'd0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
